alu_arbiter: RTL and testbench

- Shares one registered N-bit ALU (3-bit opcode, carry-in, registered result and carry-out) between two requesters.
- Arbitrates round-robin and latches the winner's operands.
- Holds those operands on the ALU inputs for the ALU's latency, captures the result and returns it to the winner over a valid/ready response channel.
- Sits between the register-file/issue logic and the ALU instance. It is the only driver of the ALU inputs.

---
 rtl/alu_ctrl_pkg.sv | 25 ++
 rtl/alu_arbiter_rr_arb2.sv | 20 ++
 rtl/alu_arbiter.sv | 150 +++++++++++++++
 tb/tb_alu_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: opcodes, controller state encoding and the carry-valid rule
// shared by the ALU arbiter (and reusable by the ALU itself).
package alu_ctrl_pkg;

  localparam logic [2:0] OP_MOV  = 3'b000;
  localparam logic [2:0] OP_NOT  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Ops whose ALU carry-out is meaningful and returned to the requester.
  function automatic logic carry_valid(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin arbiter. `last` is the id of the
// most recent winner; on contention the other requester is granted.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // One-hot grant: a lone requester always wins, a tie goes to !last.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between two requesters. Round-robin
// accept in IDLE, hold operands on the ALU for ALU_LAT+1 edges in ISSUE, then
// present the shaped result on the response channel in RESP.
// Optional grant counters are enabled by defining ALU_ARB_PERF_EN.
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int N       = 32,
  parameter int ALU_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [5:0]     req_op,
  input  logic [2*N-1:0] req_a,
  input  logic [2*N-1:0] req_b,
  input  logic [1:0]     req_cin,
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [N-1:0]   rsp_data,
  output logic           rsp_cout,
  output logic [N-1:0]   alu_in1,
  output logic [N-1:0]   alu_in2,
  output logic [2:0]     alu_op,
  output logic           alu_cin,
  input  logic [N-1:0]   alu_out,
  input  logic           alu_cout
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [15:0]    grant_cnt0,
  output logic [15:0]    grant_cnt1
`endif
);

  state_t       state;
  state_t       state_next;
  logic         rr_last;
  logic         gnt_id;
  logic [2:0]   wait_cnt;
  logic [1:0]   grant;
  logic         accept;
  logic         win;
  logic [2:0]   op_sel;
  logic [N-1:0] a_sel;
  logic [N-1:0] b_sel;
  logic         cin_sel;
  logic [N-1:0] shaped_data;
  logic         shaped_cout;

  rr_arb2 u_arb (
    .req   (req_valid),
    .last  (rr_last),
    .grant (grant)
  );

  // Only one grant bit can be set, so bit 1 is the winner id.
  assign win     = grant[1];
  assign accept  = |req_ready;
  assign op_sel  = win ? req_op[5:3]      : req_op[2:0];
  assign a_sel   = win ? req_a[2*N-1:N]   : req_a[N-1:0];
  assign b_sel   = win ? req_b[2*N-1:N]   : req_b[N-1:0];
  assign cin_sel = win ? req_cin[1]       : req_cin[0];

  // slt reports its flag as a 0/1 word; flags of non-arithmetic ops are masked.
  assign shaped_data = (alu_op == OP_SLT) ? {{(N-1){1'b0}}, alu_cout} : alu_out;
  assign shaped_cout = carry_valid(alu_op) & alu_cout;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state: accept -> hold for the ALU latency -> wait for the taker.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept)            state_next = ST_ISSUE;
      ST_ISSUE: if (wait_cnt == 3'd0)  state_next = ST_RESP;
      ST_RESP:  if (rsp_ready[gnt_id]) state_next = ST_IDLE;
      default:                         state_next = ST_IDLE;
    endcase
  end

  // Accept strobe: only in IDLE, and forced low while reset is asserted.
  always_comb begin
    req_ready = 2'b00;
    if (rst_n && (state == ST_IDLE)) req_ready = grant;
  end

  // Operand, counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last   <= 1'b1;
      gnt_id    <= 1'b0;
      wait_cnt  <= 3'd0;
      alu_in1   <= '0;
      alu_in2   <= '0;
      alu_op    <= 3'd0;
      alu_cin   <= 1'b0;
      rsp_valid <= 2'b00;
      rsp_data  <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_in1  <= a_sel;
            alu_in2  <= b_sel;
            alu_op   <= op_sel;
            alu_cin  <= cin_sel;
            gnt_id   <= win;
            rr_last  <= win;
            wait_cnt <= 3'(ALU_LAT);
          end
        end
        ST_ISSUE: begin
          if (wait_cnt == 3'd0) begin
            rsp_data  <= shaped_data;
            rsp_cout  <= shaped_cout;
            rsp_valid <= gnt_id ? 2'b10 : 2'b01;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready[gnt_id]) rsp_valid <= 2'b00;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ARB_PERF_EN
  // Saturating per-requester accept counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= 16'd0;
      grant_cnt1 <= 16'd0;
    end else begin
      if (req_ready[0] && (grant_cnt0 != 16'hFFFF)) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (req_ready[1] && (grant_cnt1 != 16'hFFFF)) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed plus randomized checks of alu_arbiter against a
// transaction-level reference (round-robin winner, latency, result shaping).
// Define ALU_ARB_PERF_EN to also exercise the grant counters.
module tb_alu_arbiter;
  import alu_ctrl_pkg::*;

  localparam int N   = 32;
  localparam int LAT = 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [1:0]     req_valid = '0;
  logic [1:0]     req_ready;
  logic [5:0]     req_op = '0;
  logic [2*N-1:0] req_a = '0;
  logic [2*N-1:0] req_b = '0;
  logic [1:0]     req_cin = '0;
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready = '0;
  logic [N-1:0]   rsp_data;
  logic           rsp_cout;
  logic [N-1:0]   alu_in1, alu_in2;
  logic [2:0]     alu_op;
  logic           alu_cin;
  logic [N-1:0]   alu_out;
  logic           alu_cout;
`ifdef ALU_ARB_PERF_EN
  logic [15:0]    grant_cnt0, grant_cnt1;
`endif

  always #5 clk = ~clk;

  alu_arbiter #(.N(N), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_cout(rsp_cout),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_cout(alu_cout)
`ifdef ALU_ARB_PERF_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  // Environment ALU: one register stage; logic ops raise a junk flag of 1.
  function automatic logic [N:0] alu_fn(input logic [2:0] op, input logic [N-1:0] a,
                                        input logic [N-1:0] b, input logic cin);
    logic [N:0] t;
    case (op)
      OP_MOV:  t = {1'b1, a};
      OP_NOT:  t = {1'b1, ~a};
      OP_ADD:  t = {1'b0, a} + {1'b0, b} + (N+1)'(cin);
      OP_NOR:  t = {1'b1, ~(a | b)};
      OP_SUB:  t = {1'b0, a} - {1'b0, b} - (N+1)'(cin);
      OP_NAND: t = {1'b1, ~(a & b)};
      OP_AND:  t = {1'b1, a & b};
      default: t = {($signed(a) < $signed(b)), ~a};
    endcase
    return t;
  endfunction

  logic [N:0] alu_q = '0;
  always @(posedge clk) alu_q <= alu_fn(alu_op, alu_in1, alu_in2, alu_cin);
  assign alu_out  = alu_q[N-1:0];
  assign alu_cout = alu_q[N];

  // Expected {cout, data} returned to the requester.
  function automatic logic [N:0] expect_rsp(input logic [2:0] op, input logic [N-1:0] a,
                                            input logic [N-1:0] b, input logic cin);
    logic [N:0] r;
    r = alu_fn(op, a, b, cin);
    if (op == OP_ADD || op == OP_SUB) return r;
    if (op == OP_SLT) return {r[N], (N)'(r[N])};
    return {1'b0, r[N-1:0]};
  endfunction

  int errors = 0;
  int checks = 0;
  int model_last = 1;
  int last_win;
  logic [N-1:0] got_data;
  logic         got_cout;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic cin);
    req_op[3*i +: 3] = op;
    req_a[N*i +: N]  = a;
    req_b[N*i +: N]  = b;
    req_cin[i]       = cin;
    req_valid[i]     = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"},  rsp_data,  0);
    check({tag, "_rsp_cout"},  rsp_cout,  0);
    check({tag, "_alu_in1"},   alu_in1,   0);
    check({tag, "_alu_in2"},   alu_in2,   0);
    check({tag, "_alu_op"},    alu_op,    0);
    check({tag, "_alu_cin"},   alu_cin,   0);
  endtask

  // One full transaction with the currently driven requests; returns the
  // number of IDLE cycles spent before the accept.
  task automatic run_op(input bit keep, input int hold, output int idle_wait);
    int win, lat;
    bit seen;
    logic [2:0] op;
    logic [N-1:0] a, b;
    logic cin;
    logic [N:0] exp;
    win = (req_valid == 2'b11) ? ((model_last == 1) ? 0 : 1) : (req_valid[1] ? 1 : 0);
    idle_wait = 0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin seen = 1; break; end
      idle_wait++;
    end
    if (!seen) begin timeout("accept"); return; end
    check("grant", req_ready, 2'b01 << win);
    op  = req_op[3*win +: 3];
    a   = req_a[N*win +: N];
    b   = req_b[N*win +: N];
    cin = req_cin[win];
    model_last = win;
    last_win = win;
    @(posedge clk); #1;
    if (!keep) req_valid[win] = 1'b0;
    lat = 0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) begin seen = 1; break; end
      if (lat == 0) begin
        check("alu_in1", alu_in1, a);
        check("alu_in2", alu_in2, b);
        check("alu_op",  alu_op,  op);
        check("alu_cin", alu_cin, cin);
      end
      check("ready_busy", req_ready, 0);
      lat++;
    end
    if (!seen) begin timeout("response"); return; end
    exp = expect_rsp(op, a, b, cin);
    check("latency",   lat,       LAT + 1);
    check("rsp_valid", rsp_valid, 2'b01 << win);
    check("rsp_data",  rsp_data,  exp[N-1:0]);
    check("rsp_cout",  rsp_cout,  exp[N]);
    got_data = rsp_data;
    got_cout = rsp_cout;
    for (int h = 0; h < hold; h++) begin
      rsp_ready = ($urandom_range(0, 1) == 1) ? (2'b01 << (1 - win)) : 2'b00;
      @(negedge clk);
      check("hold_valid", rsp_valid, 2'b01 << win);
      check("hold_data",  rsp_data,  exp[N-1:0]);
      check("hold_cout",  rsp_cout,  exp[N]);
      check("hold_ready", req_ready, 0);
    end
    rsp_ready = 2'b01 << win;
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    $display("txn req%0d op=%0d a=%h b=%h cin=%0d -> data=%h cout=%0d wait=%0d hold=%0d",
             win, op, a, b, cin, got_data, got_cout, idle_wait, hold);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_all_zero("reset");
`ifdef ALU_ARB_PERF_EN
    check("reset_cnt0", grant_cnt0, 0);
    check("reset_cnt1", grant_cnt1, 0);
`endif
    model_last = 1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int w;
    // Reset with both requests already pending: nothing may be granted.
    req_valid = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("por");
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single add accepted in the first IDLE cycle.
    set_req(0, OP_ADD, 32'd5, 32'd7, 1'b0);
    run_op(0, 0, w);
    check("add_wait", w, 0);
    check("add_data", got_data, 32'd12);
    check("add_cout", got_cout, 1'b0);

    // Overflow, slt and masked flag.
    set_req(1, OP_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op(0, 0, w);
    check("ovf_data", got_data, 32'd0);
    check("ovf_cout", got_cout, 1'b1);
    set_req(1, OP_SLT, 32'd3, 32'd9, 1'b0);
    run_op(0, 0, w);
    check("slt_data", got_data, 32'd1);
    check("slt_cout", got_cout, 1'b1);
    set_req(0, OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1);
    run_op(0, 0, w);
    check("and_cout", got_cout, 1'b0);

    // Back-pressure with the request held through RESP, then back-to-back accept.
    set_req(0, OP_SUB, 32'd10, 32'd20, 1'b0);
    run_op(1, 5, w);
    run_op(0, 0, w);
    check("next_accept_wait", w, 0);

    // Contention from reset: 0,1,0,1.
    do_reset();
    set_req(0, OP_ADD, 32'd100, 32'd1, 1'b0);
    set_req(1, OP_NOR, 32'h1, 32'h2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_op(1, i, w);
      check("rr_order", last_win, i % 2);
    end
    req_valid = 2'b00;

    // Reset while in ISSUE.
    set_req(0, OP_MOV, 32'h1234_5678, 32'h0, 1'b0);
    @(negedge clk);
    check("pre_reset_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_issue");
    model_last = 1;
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_stale_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1;

    // Post-reset: req0 first, then 3 req0 / 2 req1 in total.
    set_req(0, OP_NOT, 32'hAAAA_5555, 32'd0, 1'b0);
    set_req(1, OP_ADD, 32'd1, 32'd2, 1'b1);
    run_op(0, 0, w);
    check("post_reset_first", last_win, 0);
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      set_req((i % 2 == 0) ? 1 : 0, OP_NAND, $urandom, $urandom, 1'b0);
      run_op(0, 0, w);
    end
`ifdef ALU_ARB_PERF_EN
    check("perf_cnt0", grant_cnt0, 16'd3);
    check("perf_cnt1", grant_cnt1, 16'd2);
    force dut.grant_cnt0 = 16'hFFFF;
    @(negedge clk);
    release dut.grant_cnt0;
    set_req(0, OP_MOV, 32'd9, 32'd0, 1'b0);
    run_op(0, 0, w);
    check("perf_sat", grant_cnt0, 16'hFFFF);
    check("perf_cnt1_hold", grant_cnt1, 16'd2);
`endif

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] pat;
      pat = 2'($urandom_range(1, 3));
      req_valid = 2'b00;
      for (int r = 0; r < 2; r++) begin
        if (pat[r]) begin
          set_req(r, 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom),
                  32'($urandom), 1'($urandom_range(0, 1)));
        end
      end
      run_op(1'($urandom_range(0, 1)), $urandom_range(0, 3), w);
    end
    req_valid = 2'b00;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
